// File: rtl/exc_tracker_if.sv
// -----------------------------------------------------------------------------
// exc_tracker_if
//   Bundles the pipeline-side signals of the exception tracker.
//
//   Pipeline -> tracker
//     advance     : every stage shifts one position this cycle
//     in_valid    : an instruction enters stage 0
//     in_bd       : entering instruction sits in a branch delay slot
//     in_pc       : PC of the entering instruction
//     stage_code  : code raised by stage i, slice [i*CODE_W +: CODE_W]
//     irq, irq_en : level interrupt request, global interrupt enable
//     eret        : instruction at the commit stage is ERET
//   Tracker -> pipeline
//     exc_req     : one-cycle pulse, take exception and flush
//     exc_code    : committed code (0 for an interrupt)
//     exc_epc     : return PC of the victim instruction
//     exc_bd      : victim was in a delay slot
//     exl         : handler active
//     eret_flush  : one-cycle pulse on a committed ERET
//     exc_cnt     : saturating exception count (only with EXC_TRACKER_CNT_EN)
//
//   Modports: master = pipeline side, slave = tracker side.
//   Optional feature macro: EXC_TRACKER_CNT_EN
// -----------------------------------------------------------------------------
interface exc_tracker_if #(
    parameter int NSTAGE = 4,
    parameter int PC_W   = 32,
    parameter int CODE_W = 5
);
    logic                     advance;
    logic                     in_valid;
    logic                     in_bd;
    logic [PC_W-1:0]          in_pc;
    logic [NSTAGE*CODE_W-1:0] stage_code;
    logic                     irq;
    logic                     irq_en;
    logic                     eret;

    logic                     exc_req;
    logic [CODE_W-1:0]        exc_code;
    logic [PC_W-1:0]          exc_epc;
    logic                     exc_bd;
    logic                     exl;
    logic                     eret_flush;

`ifdef EXC_TRACKER_CNT_EN
    logic [15:0]              exc_cnt;

    modport master (
        output advance, in_valid, in_bd, in_pc, stage_code, irq, irq_en, eret,
        input  exc_req, exc_code, exc_epc, exc_bd, exl, eret_flush, exc_cnt
    );

    modport slave (
        input  advance, in_valid, in_bd, in_pc, stage_code, irq, irq_en, eret,
        output exc_req, exc_code, exc_epc, exc_bd, exl, eret_flush, exc_cnt
    );
`else
    modport master (
        output advance, in_valid, in_bd, in_pc, stage_code, irq, irq_en, eret,
        input  exc_req, exc_code, exc_epc, exc_bd, exl, eret_flush
    );

    modport slave (
        input  advance, in_valid, in_bd, in_pc, stage_code, irq, irq_en, eret,
        output exc_req, exc_code, exc_epc, exc_bd, exl, eret_flush
    );
`endif

endinterface

// File: rtl/exc_tracker.sv
// -----------------------------------------------------------------------------
// exc_tracker
//   Precise-exception tracker for an in-order pipeline of NSTAGE stages
//   (stage 0 = fetch, stage NSTAGE-1 = commit). Each stage carries the
//   valid bit, delay-slot flag, PC and the first exception code raised for
//   its instruction. Codes are resolved only when the instruction commits,
//   so the oldest instruction's earliest-detected exception always wins.
//
//   Ports
//     clk    : sole clock, rising edge
//     reset  : synchronous, active-high reset
//     bus    : exc_tracker_if.slave (see interface header for signal list)
//
//   Parameters
//     NSTAGE : stages tracked (2..8)
//     PC_W   : PC width
//     CODE_W : exception-code width, code 0 = none
//
//   Optional feature macro: EXC_TRACKER_CNT_EN
//     When defined, bus.exc_cnt is a 16-bit saturating count of exc_req
//     cycles. When undefined there is no counter and no exc_cnt signal.
// -----------------------------------------------------------------------------
module exc_tracker #(
    parameter int NSTAGE = 4,
    parameter int PC_W   = 32,
    parameter int CODE_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    exc_tracker_if.slave  bus
);

    localparam int LAST = NSTAGE - 1;

    typedef enum logic {
        NORMAL  = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              st_valid [NSTAGE];
    logic              st_bd    [NSTAGE];
    logic [PC_W-1:0]   st_pc    [NSTAGE];
    logic [CODE_W-1:0] st_code  [NSTAGE];
    logic [CODE_W-1:0] eff_code [NSTAGE];

    logic              commit_en;
    logic              irq_take;
    logic              exc_take;
    logic              eret_take;
    logic              flush;

    logic [PC_W-1:0]   epc_q;
    logic              epc_bd_q;

    // Return address of the victim: a delay-slot instruction restarts at its
    // branch, one word earlier. Subtraction wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] victim_epc(input logic [PC_W-1:0] pc,
                                                   input logic            bd);
        return bd ? (pc - PC_W'(4)) : pc;
    endfunction

`ifdef EXC_TRACKER_CNT_EN
    logic [15:0] exc_cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction
`endif

    // A code already carried by the instruction beats anything raised later
    // in the pipe; an empty stage contributes nothing.
    always_comb begin
        for (int i = 0; i < NSTAGE; i++) begin
            eff_code[i] = '0;
            if (st_valid[i]) begin
                eff_code[i] = (st_code[i] != '0) ? st_code[i]
                                                 : bus.stage_code[i*CODE_W +: CODE_W];
            end
        end
    end

    // Commit resolution and handler-state next-state logic. Interrupts are
    // masked while a handler runs; ERET only flushes when a handler is active.
    always_comb begin
        state_nxt      = state;
        commit_en      = 1'b0;
        irq_take       = 1'b0;
        exc_take       = 1'b0;
        eret_take      = 1'b0;
        bus.exc_req    = 1'b0;
        bus.exc_code   = '0;
        bus.eret_flush = 1'b0;

        commit_en = bus.advance && st_valid[LAST] && !reset;
        irq_take  = bus.irq && bus.irq_en && (state == NORMAL);
        exc_take  = commit_en && (irq_take || (eff_code[LAST] != '0));
        eret_take = commit_en && !exc_take && bus.eret && (state == HANDLER);

        bus.exc_req    = exc_take;
        bus.eret_flush = eret_take;
        if (exc_take && !irq_take) begin
            bus.exc_code = eff_code[LAST];
        end

        case (state)
            NORMAL:  if (exc_take)  state_nxt = HANDLER;
            HANDLER: if (eret_take) state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    assign flush   = exc_take || eret_take;
    assign bus.exl = (state == HANDLER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= NORMAL;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage control: valid bits and carried codes. A flush wins over an
    // instruction entering in the same cycle. Without advance every stage
    // holds but latches its effective code, so a transient code is kept.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < NSTAGE; i++) begin
                st_valid[i] <= 1'b0;
                st_code[i]  <= '0;
            end
        end else if (bus.advance) begin
            st_valid[0] <= bus.in_valid;
            st_code[0]  <= '0;
            for (int i = 1; i < NSTAGE; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_code[i]  <= eff_code[i-1];
            end
        end else begin
            for (int i = 0; i < NSTAGE; i++) begin
                st_code[i] <= eff_code[i];
            end
        end
    end

    // Stage payload: only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (bus.advance) begin
            st_pc[0] <= bus.in_pc;
            st_bd[0] <= bus.in_bd;
            for (int i = 1; i < NSTAGE; i++) begin
                st_pc[i] <= st_pc[i-1];
                st_bd[i] <= st_bd[i-1];
            end
        end
    end

    // Victim capture: a nested exception inside a handler keeps the
    // original return address.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc_q    <= '0;
            epc_bd_q <= 1'b0;
        end else if (exc_take && (state == NORMAL)) begin
            epc_q    <= victim_epc(st_pc[LAST], st_bd[LAST]);
            epc_bd_q <= st_bd[LAST];
        end
    end

    assign bus.exc_epc = epc_q;
    assign bus.exc_bd  = epc_bd_q;

`ifdef EXC_TRACKER_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_cnt_q <= '0;
        end else if (exc_take) begin
            exc_cnt_q <= sat_inc16(exc_cnt_q);
        end
    end

    assign bus.exc_cnt = exc_cnt_q;
`endif

endmodule

// File: doc/exc_tracker.md
EXC_TRACKER -- requirements
Module: exc_tracker

Interface
REQ-001 SHALL have parameter NSTAGE, default 4, pipeline stages tracked (2..8; stage 0 = F, stage NSTAGE-1 = commit).
REQ-002 SHALL have parameter PC_W, default 32, PC width.
REQ-003 SHALL have parameter CODE_W, default 5, exception-code width; code 0 = none.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port advance  in  1  all stages shift one position this cycle.
REQ-007 SHALL have port in_valid, in_bd  in  1 each  instruction entering stage 0; delay-slot flag.
REQ-008 SHALL have port in_pc  in  PC_W  PC of entering instruction.
REQ-009 SHALL have port stage_code  in  NSTAGE*CODE_W  code raised by stage i this cycle, slice [i*CODE_W +: CODE_W].
REQ-010 SHALL have port irq, irq_en  in  1 each  level interrupt request; global interrupt enable.
REQ-011 SHALL have port eret  in  1  instruction at commit stage is ERET.
REQ-012 SHALL have port exc_req  out  1  one-cycle pulse: take exception, flush pipeline.
REQ-013 SHALL have port exc_code  out  CODE_W  committed code (0 for interrupt).
REQ-014 SHALL have port exc_epc  out  PC_W, exc_bd  out  1  victim return PC; victim delay-slot flag.
REQ-015 SHALL have port exl  out  1  handler-active state.
REQ-016 SHALL have port eret_flush  out  1  one-cycle pulse on committed ERET.

Function
REQ-017 SHALL hold per stage: valid, bd, pc, carried code.
REQ-018 SHALL compute effective code of stage i = carried_i if nonzero, else stage_code slice i (earliest-detected exception wins); invalid stage effective code = 0.
REQ-019 SHALL, on advance=1: stage 0 <= in_* with carried 0; stage i+1 <= stage i with carried = effective code of stage i.
REQ-020 SHALL, on advance=0: every stage holds, carried_i <= effective code of stage i (sticky capture).
REQ-021 SHALL evaluate commit only when advance=1 and commit-stage valid=1.
REQ-022 SHALL, at commit, give priority: interrupt (irq & irq_en & !exl) > nonzero effective code > eret.
REQ-023 SHALL, on interrupt or exception commit, pulse exc_req same cycle (combinational), exc_code = 0 or effective code.
REQ-024 SHALL, on exc_req with exl=0, register exc_epc = bd ? pc-4 : pc and exc_bd = bd next cycle; with exl=1, exc_epc and exc_bd hold.
REQ-025 SHALL, on exc_req, clear all stage valid bits and carried codes next cycle and set exl.
REQ-026 SHALL, on eret commit with exl=1, pulse eret_flush, clear exl and flush all stages next cycle; eret with exl=0 is a normal instruction.
REQ-027 SHALL use two-state FSM NORMAL (exl=0) / HANDLER (exl=1); NORMAL->HANDLER on exc_req, HANDLER->NORMAL on eret_flush; exc_req in HANDLER stays HANDLER.
REQ-028 SHALL flush and shift simultaneously-accepted in_* on exc_req/eret_flush cycles: flush wins, stage 0 cleared.
REQ-029 SHALL compute pc-4 modulo 2^PC_W (wraps at 0).

Reset
REQ-030 SHALL, on reset, clear all stages, exl=0, exc_epc=0, exc_bd=0; exc_req and eret_flush 0 during reset; reset overrides advance, commit and flush in the same cycle.

Configuration
REQ-031 SHALL, with EXC_TRACKER_CNT_EN defined, add output exc_cnt (16 bits): reset 0, +1 per exc_req cycle, saturates at 16'hFFFF.
REQ-032 SHALL, without EXC_TRACKER_CNT_EN, have no exc_cnt port and no counter logic.

Verification
REQ-033 SHALL test: stage 2 raises code 12 for pc 0x3008, advance every cycle -> exc_req at commit, exc_code=12, exc_epc=0x3008, exl=1.
REQ-034 SHALL test: same instruction raises 4 in stage 1 and 5 in stage 3 -> exc_code=4.
REQ-035 SHALL test: irq=1, irq_en=1, commit valid, code 10, bd=1, pc 0x3010 -> exc_code=0, exc_epc=0x300C, exc_bd=1.
REQ-036 SHALL test: exl=1, eret commit -> eret_flush=1, exl=0 next cycle, all stages invalid; irq masked during HANDLER.
REQ-037 SHALL test: code raised in stage 1 while advance=0 for 3 cycles then deasserted -> code still reported at commit.
REQ-038 SHALL test: reset asserted same cycle as exception commit -> no exc_req, exl=0, exc_epc=0; with EXC_TRACKER_CNT_EN, 65536 exceptions -> exc_cnt=16'hFFFF.
